writeback_register_file: RTL

Writeback stage and architectural register file of the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects the writeback value (memory data, ALU result or link address), and commits it into a 32 x 32-bit register file. It provides two read ports with same-cycle write bypass to the ID stage, and keeps a retired-write counter for debug.

---
 rtl/writeback_register_file.sv | 113 +++++++++++
 1 files changed

// File: rtl/writeback_register_file.sv
// -----------------------------------------------------------------------------
// writeback_register_file
//
// Writeback stage plus the 32 x N architectural register file of the
// five-stage MIPS pipeline. The MEM/WB entry selects a writeback value
// (ALU result, load data or the jal link address). When the entry writes a
// non-zero register, that value is committed on the next rising edge.
// Two combinational read ports serve the ID stage. Each read port has a
// write-first bypass, so ID sees a value in the same cycle it is written back.
//
// Ports:
//   clk            system clock, rising-edge active
//   reset          synchronous, active-high reset
//   WB_Control     [2] RegWrite, [1:0] MemtoReg
//   ReadData_WB    load value from MEM/WB
//   ALURes         ALU result from MEM/WB
//   PC2            PC+4 link address from MEM/WB
//   WriteRegister  destination register index
//   ReadRegister1  ID-stage rs index
//   ReadRegister2  ID-stage rt index
//   ReadData1      rs value, bypassed
//   ReadData2      rt value, bypassed
//   WriteData      selected writeback value (also the EX forwarding source)
//   WriteEnable    RegWrite qualified by WriteRegister != 0
//   RetiredWrites  count of committed register writes (wraps silently)
//
// Handshake: there is no valid/ready pair. One MEM/WB entry is accepted
// every cycle. Bubbles arrive with RegWrite = 0.
// -----------------------------------------------------------------------------
module writeback_register_file #(
   parameter int              N       = 32,
   parameter logic [N-1:0]    SP_INIT = 32'h7FFF_EFFC
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    WB_Control,
   input  logic [N-1:0]  ReadData_WB,
   input  logic [N-1:0]  ALURes,
   input  logic [N-1:0]  PC2,
   input  logic [4:0]    WriteRegister,
   input  logic [4:0]    ReadRegister1,
   input  logic [4:0]    ReadRegister2,
   output logic [N-1:0]  ReadData1,
   output logic [N-1:0]  ReadData2,
   output logic [N-1:0]  WriteData,
   output logic          WriteEnable,
   output logic [31:0]   RetiredWrites
);

   localparam logic [4:0] SP_INDEX = 5'd29;

   logic          regWrite;
   logic [1:0]    memToReg;
   logic [N-1:0]  regs [0:31];
   logic [31:0]   retiredCount;

   assign regWrite = WB_Control[2];
   assign memToReg = WB_Control[1:0];

   // Writeback select. The reserved encoding 2'b11 behaves as an ALU writeback.
   always_comb begin
      WriteData = ALURes;
      case (memToReg)
         2'b01:   WriteData = ReadData_WB;
         2'b10:   WriteData = PC2;
         default: WriteData = ALURes;
      endcase
   end

   // Writes to $zero are dropped here, so they are neither committed nor counted.
   assign WriteEnable = regWrite && (WriteRegister != 5'd0);

   // Read ports: $zero is hardwired to 0. Otherwise a matching write in flight
   // wins over the array contents (write-first).
   always_comb begin
      ReadData1 = regs[ReadRegister1];
      if (ReadRegister1 == 5'd0)
         ReadData1 = '0;
      else if (WriteEnable && (ReadRegister1 == WriteRegister))
         ReadData1 = WriteData;
   end

   always_comb begin
      ReadData2 = regs[ReadRegister2];
      if (ReadRegister2 == 5'd0)
         ReadData2 = '0;
      else if (WriteEnable && (ReadRegister2 == WriteRegister))
         ReadData2 = WriteData;
   end

   // Register array. Reset has priority over a write presented in the same
   // cycle. Entry 0 is cleared on reset and never written afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (5'(i) == SP_INDEX) ? SP_INIT : '0;
         end
      end else if (WriteEnable) begin
         regs[WriteRegister] <= WriteData;
      end
   end

   // Retired-write counter. It wraps from all-ones to zero with no flag.
   always_ff @(posedge clk) begin
      if (reset)
         retiredCount <= '0;
      else if (WriteEnable)
         retiredCount <= retiredCount + 32'd1;
   end

   assign RetiredWrites = retiredCount;

endmodule
